// File: rtl/fphub_special_case_detector.sv
// fphub_special_case_detector
//   Operand classifier at the input of the HUB floating-point multiplier.
//   Each operand of a pair (X, Y) is classified combinationally into a
//   special-case code. The codes are registered together with the operands
//   in a valid/ready stage that has a skid buffer. A saturating counter
//   tracks the special pairs that are delivered downstream.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       upstream handshake (in_ready from registered skid state)
//   X, Y                      operands {sign, exp[E-1:0], man[M-1:0]}
//   out_valid / out_ready     downstream handshake
//   X_out, Y_out              registered operands
//   X_special_case,
//   Y_special_case            case codes belonging to X_out / Y_out
//   is_special                either code is not NONE
//   count_clr                 synchronous clear of special_count
//   special_count             saturating count of delivered special pairs
module fphub_special_case_detector #(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7,
  parameter int CNT_W        = 16,
  localparam int CW          = $clog2(special_case),
  localparam int W           = E + M + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     X,
  input  logic [W-1:0]     Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     X_out,
  output logic [W-1:0]     Y_out,
  output logic [CW-1:0]    X_special_case,
  output logic [CW-1:0]    Y_special_case,
  output logic             is_special,
  input  logic             count_clr,
  output logic [CNT_W-1:0] special_count
);

  typedef enum logic [CW-1:0] {
    NONE   = 0,
    INF_P  = 1,
    INF_N  = 2,
    ZERO_P = 3,
    ZERO_N = 4,
    ONE_P  = 5,
    ONE_N  = 6
  } code_e;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    code_e        xc;
    code_e        yc;
  } pair_t;

  function automatic code_e classify(input logic [W-1:0] v);
    logic [E-1:0] ex;
    logic [M-1:0] man;
    logic         sgn;
    code_e        c;
    ex  = v[W-2:M];
    man = v[M-1:0];
    sgn = v[W-1];
    c   = NONE;
    if ((&ex) && (&man))
      c = sgn ? INF_N : INF_P;
    else if ((ex == '0) && (man == '0))
      c = sgn ? ZERO_N : ZERO_P;
    else if ((ex == {1'b1, {(E-1){1'b0}}}) && (man == '0))
      c = sgn ? ONE_N : ONE_P;
    return c;
  endfunction

  pair_t            main_q, main_d;
  pair_t            skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  pair_t in_pair;
  logic  accept;
  logic  fire;

  // in_ready depends only on registered skid state (and reset), never on out_ready.
  assign in_ready       = !skid_valid_q && !rst;
  assign out_valid      = main_valid_q;
  assign X_out          = main_q.x;
  assign Y_out          = main_q.y;
  assign X_special_case = main_q.xc;
  assign Y_special_case = main_q.yc;
  assign is_special     = (main_q.xc != NONE) || (main_q.yc != NONE);
  assign special_count  = cnt_q;

  always_comb begin
    in_pair.x  = X;
    in_pair.y  = Y;
    in_pair.xc = classify(X);
    in_pair.yc = classify(Y);

    accept = in_valid && in_ready;
    fire   = main_valid_q && out_ready;

    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;

    if (!main_valid_q || fire) begin
      if (skid_valid_q) begin
        // Skid holds the older pair; it must leave first to keep ordering.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_pair;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_pair;
      skid_valid_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (count_clr)
      cnt_d = '0;
    else if (fire && is_special && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fphub_special_case_detector.sv
// Bench for fphub_special_case_detector: a wide-counter instance and a
// 4-bit-counter instance share one stimulus stream and are checked against
// a queue-based reference model.
module tb_fphub_special_case_detector;

  localparam int M  = 23;
  localparam int E  = 8;
  localparam int W  = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready, count_clr;
  logic [W-1:0]  X, Y;

  logic          in_ready_a, out_valid_a, is_sp_a;
  logic [W-1:0]  x_out_a, y_out_a;
  logic [CW-1:0] xc_a, yc_a;
  logic [15:0]   cnt_a;

  logic          in_ready_b, out_valid_b, is_sp_b;
  logic [W-1:0]  x_out_b, y_out_b;
  logic [CW-1:0] xc_b, yc_b;
  logic [3:0]    cnt_b;

  fphub_special_case_detector #(.M(M), .E(E), .special_case(7), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .X(X), .Y(Y), .out_valid(out_valid_a), .out_ready(out_ready),
    .X_out(x_out_a), .Y_out(y_out_a), .X_special_case(xc_a), .Y_special_case(yc_a),
    .is_special(is_sp_a), .count_clr(count_clr), .special_count(cnt_a));

  fphub_special_case_detector #(.M(M), .E(E), .special_case(7), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .X(X), .Y(Y), .out_valid(out_valid_b), .out_ready(out_ready),
    .X_out(x_out_b), .Y_out(y_out_b), .X_special_case(xc_b), .Y_special_case(yc_b),
    .is_special(is_sp_b), .count_clr(count_clr), .special_count(cnt_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
  } pair_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           xc;
    int           yc;
    bit           sp;
  } vec_t;

  pair_t       q[$];
  int unsigned cnt16, cnt4;
  bit          zero_data;
  bit          prev_rst;
  int          nchk, nfail;

  // Classification straight from the format rules using integer arithmetic.
  function automatic int model_code(input logic [W-1:0] v);
    longint unsigned vv, man, ex, s;
    int base;
    vv   = v;
    man  = vv % (64'd1 << M);
    ex   = (vv >> M) % (64'd1 << E);
    s    = vv >> (E + M);
    base = 0;
    if (ex == (64'd1 << E) - 1 && man == (64'd1 << M) - 1) base = 1;
    else if (ex == 0 && man == 0)                         base = 3;
    else if (ex == (64'd1 << (E - 1)) && man == 0)        base = 5;
    return (base == 0) ? 0 : base + int'(s);
  endfunction

  function automatic bit pair_special(input pair_t p);
    return (model_code(p.x) != 0) || (model_code(p.y) != 0);
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] pool [10];
    pool = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h40000000,
             32'hC0000000, 32'h7F800000, 32'h3F800000, 32'h40000001, 32'h7FFFFFFE};
    if ($urandom_range(0, 4) < 3) return pool[$urandom_range(0, 9)];
    return $urandom;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called right after a negedge with inputs already driven; checks, advances
  // the model across the posedge and returns at the next negedge.
  task automatic cycle();
    bit acc, fire;
    pair_t f;
    #3;
    chk("in_ready_a", in_ready_a, (!rst && q.size() < 2));
    chk("in_ready_b", in_ready_b, (!rst && q.size() < 2));
    if (!rst || prev_rst) begin
      chk("out_valid_a", out_valid_a, q.size() > 0);
      chk("out_valid_b", out_valid_b, q.size() > 0);
      if (q.size() > 0) begin
        f = q[0];
        chk("x_out", x_out_a, f.x);
        chk("y_out", y_out_a, f.y);
        chk("x_code", xc_a, model_code(f.x));
        chk("y_code", yc_a, model_code(f.y));
        chk("is_special", is_sp_a, pair_special(f));
        chk("x_out_b", x_out_b, f.x);
        chk("x_code_b", xc_b, model_code(f.x));
        chk("is_special_b", is_sp_b, pair_special(f));
      end else if (zero_data) begin
        chk("x_out_rst", x_out_a, 0);
        chk("y_out_rst", y_out_a, 0);
        chk("codes_rst", {xc_a, yc_a, yc_b, y_out_b}, 0);
        chk("is_special_rst", is_sp_a, 0);
      end
      chk("count_a", cnt_a, cnt16);
      chk("count_b", cnt_b, cnt4);
    end
    acc  = in_valid && !rst && (q.size() < 2);
    fire = !rst && (q.size() > 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt16 = 0;
      cnt4  = 0;
      zero_data = 1'b1;
    end else begin
      if (count_clr) begin
        cnt16 = 0;
        cnt4  = 0;
      end else if (fire && pair_special(q[0])) begin
        if (cnt16 < 65535) cnt16++;
        if (cnt4 < 15) cnt4++;
      end
      if (fire) void'(q.pop_front());
      if (acc) begin
        f.x = X;
        f.y = Y;
        q.push_back(f);
        zero_data = 1'b0;
      end
    end
    prev_rst = rst;
    @(negedge clk);
  endtask

  vec_t tbl [8];

  initial begin
    int unsigned base, nsp;
    nchk = 0; nfail = 0;
    cnt16 = 0; cnt4 = 0; zero_data = 1'b0; prev_rst = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; count_clr = 1'b0;
    X = '0; Y = '0;

    tbl[0] = '{32'h7FFFFFFF, 32'h3F800000, 1, 0, 1'b1};
    tbl[1] = '{32'hFFFFFFFF, 32'h3F800000, 2, 0, 1'b1};
    tbl[2] = '{32'h00000000, 32'h3F800000, 3, 0, 1'b1};
    tbl[3] = '{32'h80000000, 32'h3F800000, 4, 0, 1'b1};
    tbl[4] = '{32'h40000000, 32'h3F800000, 5, 0, 1'b1};
    tbl[5] = '{32'hC0000000, 32'h3F800000, 6, 0, 1'b1};
    tbl[6] = '{32'h3F800000, 32'h3F800000, 0, 0, 1'b0};
    tbl[7] = '{32'h7F800000, 32'h3F800000, 0, 0, 1'b0};

    // Reset
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Directed classification vectors, one per cycle, output one cycle later
    for (int i = 0; i < 8; i++) begin
      X = tbl[i].x; Y = tbl[i].y; in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      chk("tbl_valid", out_valid_a, 1);
      chk("tbl_xcode", xc_a, tbl[i].xc);
      chk("tbl_ycode", yc_a, tbl[i].yc);
      chk("tbl_special", is_sp_a, tbl[i].sp);
    end
    in_valid = 1'b0;
    cycle();

    // Back-to-back stream of 20 pairs
    base = cnt16; nsp = 0;
    for (int i = 0; i < 20; i++) begin
      pair_t p;
      X = rand_op(); Y = rand_op(); in_valid = 1'b1;
      p.x = X; p.y = Y;
      if (pair_special(p)) nsp++;
      cycle();
      chk("stream_in_ready", in_ready_a, 1);
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_count", cnt_a, base + nsp);

    // Backpressure: 3 stalled cycles in the middle of a stream
    for (int i = 0; i < 10; i++) begin
      X = rand_op(); Y = rand_op(); in_valid = 1'b1;
      out_ready = !(i >= 2 && i < 5);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // Counter saturation on the 4-bit instance, then clear beats increment
    X = '0; Y = '0; in_valid = 1'b1;
    repeat (20) cycle();
    in_valid = 1'b0;
    cycle();
    chk("sat4", cnt_b, 15);
    in_valid = 1'b1; X = 32'hFFFFFFFF;
    cycle();
    in_valid = 1'b0; count_clr = 1'b1;
    cycle();
    count_clr = 1'b0;
    cycle();
    chk("clr_prio_b", cnt_b, 0);
    chk("clr_prio_a", cnt_a, 0);

    // Reset with main and skid both full
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      X = rand_op(); Y = 32'h00000000;
      cycle();
    end
    rst = 1'b1;
    cycle();
    chk("rst_valid", out_valid_a, 0);
    chk("rst_count", cnt_a, 0);
    cycle();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("post_rst_ready", in_ready_a, 1);
    #(-0);
    @(negedge clk);
    repeat (3) cycle();

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 400; i++) begin
      X = rand_op(); Y = rand_op();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      count_clr = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; count_clr = 1'b0;
    repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
